// File: rtl/jtdd_irqctl.sv
// jtdd_irqctl: interrupt latch unit with per-channel edge/level mode,
// polarity, enable mask and write-1-to-clear acknowledge. Pending status and
// a priority-encoded vector are exposed for CPU glue and a small register port.
module jtdd_irqctl #(
  parameter int             NCH      = 3,
  parameter int             SYNC     = 2,
  parameter logic [NCH-1:0] MODE_RST = {NCH{1'b1}},
  parameter logic [NCH-1:0] POL_RST  = {NCH{1'b1}},
  parameter logic [NCH-1:0] MASK_RST = {NCH{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic [NCH-1:0] sig,
  input  logic           hold,
  input  logic           wr,
  input  logic [1:0]     addr,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] clr,
  output logic [7:0]     dout,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] irqn,
  output logic           any,
  output logic [2:0]     vec
);

  logic [NCH-1:0] sync_sig;
  logic           sync_ok;

  logic [NCH-1:0] mask_r, mode_r, pol_r;
  logic [NCH-1:0] hist, latch, latch_nxt;
  logic [NCH-1:0] pend_r;
  logic [2:0]     vec_r;
  logic           armed;

  logic           wr_en, wr_mask, wr_clr, wr_mode, wr_pol;
  logic [NCH-1:0] s, s_next, pol_next, rise, clear_v, pend_nxt;

  // Lowest-numbered set bit wins; returns 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [NCH-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  generate
    if (SYNC > 0) begin : g_sync
      logic [NCH-1:0]  stage [SYNC];
      logic [SYNC-1:0] fill;

      // Synchroniser chain runs on every clk; fill marks when its output holds real samples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < SYNC; k++) stage[k] <= '0;
          fill <= '0;
        end else begin
          stage[0] <= sig;
          for (int k = 1; k < SYNC; k++) stage[k] <= stage[k-1];
          fill <= (fill << 1) | SYNC'(1);
        end
      end

      assign sync_sig = stage[SYNC-1];
      assign sync_ok  = fill[SYNC-1];
    end else begin : g_nosync
      assign sync_sig = sig;
      assign sync_ok  = 1'b1;
    end
  endgenerate

  assign wr_en   = cen & wr;
  assign wr_mask = wr_en & (addr == 2'd0);
  assign wr_clr  = wr_en & (addr == 2'd1);
  assign wr_mode = wr_en & (addr == 2'd2);
  assign wr_pol  = wr_en & (addr == 2'd3);

  // Normalise polarity, detect edges and compute the next latch state.
  always_comb begin
    s        = sync_sig ~^ pol_r;
    pol_next = wr_pol ? din : pol_r;
    s_next   = sync_sig ~^ pol_next;
    rise     = s & ~hist & {NCH{armed}};
    clear_v  = (wr_clr ? din : '0) | clr;
    latch_nxt = latch;
    for (int i = 0; i < NCH; i++) begin
      if (mode_r[i]) latch_nxt[i] = (rise[i] & ~hold) | (latch[i] & ~clear_v[i]);
      else           latch_nxt[i] = s[i];
    end
  end

  // Configuration registers, edge history and latches advance only on cen cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r <= MASK_RST;
      mode_r <= MODE_RST;
      pol_r  <= POL_RST;
      hist   <= '0;
      latch  <= '0;
      armed  <= 1'b0;
    end else if (cen) begin
      if (wr_mask) mask_r <= din;
      if (wr_mode) mode_r <= din;
      pol_r <= pol_next;
      hist  <= s_next;
      latch <= latch_nxt;
      armed <= armed | sync_ok;
    end
  end

  assign pend_nxt = latch & mask_r;

  // Registered request outputs; pend and vec are loaded together so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
      vec_r  <= '0;
    end else begin
      pend_r <= pend_nxt;
      vec_r  <= lowest_set(pend_nxt);
    end
  end

  assign pend = pend_r;
  assign irqn = ~pend_r;
  assign any  = |pend_r;
  assign vec  = vec_r;

  // Register readback; held at zero while reset is asserted.
  always_comb begin
    dout = '0;
    if (!rst) begin
      case (addr)
        2'd0:    dout[NCH-1:0] = mask_r;
        2'd1:    dout[NCH-1:0] = latch;
        2'd2:    dout[NCH-1:0] = mode_r;
        default: dout[NCH-1:0] = pol_r;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_irqctl.sv
// tb_jtdd_irqctl: directed scoreboard bench for jtdd_irqctl with default parameters.
module tb_jtdd_irqctl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       cen  = 1'b1;
  logic       hold = 1'b0;
  logic       wr   = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [2:0] sig  = 3'd0;
  logic [2:0] din  = 3'd0;
  logic [2:0] clr  = 3'd0;
  logic [7:0] dout;
  logic [2:0] pend, irqn, vec;
  logic       any;

  typedef struct {
    string      tag;
    logic [2:0] pend;
    logic [1:0] rd_addr;
    logic [7:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  jtdd_irqctl dut (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .sig  (sig),
    .hold (hold),
    .wr   (wr),
    .addr (addr),
    .din  (din),
    .clr  (clr),
    .dout (dout),
    .pend (pend),
    .irqn (irqn),
    .any  (any),
    .vec  (vec)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  function automatic logic [2:0] lowestSet(input logic [2:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 2; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] s_v, input logic h_v, input logic c_v, input logic [2:0] k_v);
    sig  = s_v;
    hold = h_v;
    cen  = c_v;
    clr  = k_v;
  endtask

  task automatic regWrite(input logic [1:0] a, input logic [2:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
    din  = 3'd0;
  endtask

  task automatic pushExpect(input string tag, input logic [2:0] p, input logic [1:0] ra, input logic [7:0] d);
    exp_t e;
    e.tag = tag; e.pend = p; e.rd_addr = ra; e.dout = d;
    exp_q.push_back(e);
  endtask

  task automatic popAndCheck();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      addr = e.rd_addr;
      #1;
      checkOutput({e.tag, ".pend"}, {5'd0, pend}, {5'd0, e.pend});
      checkOutput({e.tag, ".irqn"}, {5'd0, irqn}, {5'd0, ~e.pend});
      checkOutput({e.tag, ".any"},  {7'd0, any},  {7'd0, |e.pend});
      checkOutput({e.tag, ".vec"},  {5'd0, vec},  {5'd0, lowestSet(e.pend)});
      checkOutput({e.tag, ".dout"}, dout, e.dout);
    end
  endtask

  initial begin
    // reset values, including readback held at zero during reset
    tick(2);
    pushExpect("reset", 3'b000, 2'd0, 8'h00); popAndCheck();
    rst = 1'b0;
    tick(5);
    pushExpect("mask_rst", 3'b000, 2'd0, 8'h07); popAndCheck();
    pushExpect("mode_rst", 3'b000, 2'd2, 8'h07); popAndCheck();
    pushExpect("pol_rst",  3'b000, 2'd3, 8'h07); popAndCheck();

    // one-cycle pulse on ch1: latch after 3 clk, pend one clk later
    applyStimulus(3'b010, 1'b0, 1'b1, 3'b000);
    tick(1);
    sig = 3'b000;
    tick(2);
    pushExpect("pulse_latch", 3'b000, 2'd1, 8'h02); popAndCheck();
    tick(1);
    pushExpect("pulse_pend", 3'b010, 2'd1, 8'h02); popAndCheck();
    regWrite(2'd1, 3'b010);
    pushExpect("ack_lag", 3'b010, 2'd1, 8'h00); popAndCheck();
    tick(1);
    pushExpect("ack", 3'b000, 2'd1, 8'h00); popAndCheck();

    // two channels together, priority order as each is acknowledged
    applyStimulus(3'b101, 1'b0, 1'b1, 3'b000);
    tick(5);
    pushExpect("two_edges", 3'b101, 2'd1, 8'h05); popAndCheck();
    regWrite(2'd1, 3'b001);
    tick(1);
    pushExpect("clr0", 3'b100, 2'd1, 8'h04); popAndCheck();
    regWrite(2'd1, 3'b100);
    tick(1);
    pushExpect("clr2", 3'b000, 2'd1, 8'h00); popAndCheck();
    sig = 3'b000;
    tick(5);

    // level mode on ch1: clear ignored while high, drops one cen after fall
    regWrite(2'd2, 3'b101);
    sig = 3'b010;
    tick(5);
    pushExpect("level_set", 3'b010, 2'd2, 8'h05); popAndCheck();
    regWrite(2'd1, 3'b010);
    tick(2);
    pushExpect("level_noclr", 3'b010, 2'd1, 8'h02); popAndCheck();
    sig = 3'b000;
    tick(3);
    pushExpect("level_drop_lat", 3'b010, 2'd1, 8'h00); popAndCheck();
    tick(1);
    pushExpect("level_drop", 3'b000, 2'd1, 8'h00); popAndCheck();
    regWrite(2'd2, 3'b111);
    tick(2);

    // set beats a simultaneous clr strobe; mask gates outputs only
    sig = 3'b100;
    tick(2);
    clr = 3'b100;
    tick(1);
    clr = 3'b000;
    tick(2);
    pushExpect("set_wins", 3'b100, 2'd1, 8'h04); popAndCheck();
    regWrite(2'd0, 3'b011);
    tick(1);
    pushExpect("masked", 3'b000, 2'd1, 8'h04); popAndCheck();
    regWrite(2'd0, 3'b111);
    tick(1);
    pushExpect("unmasked", 3'b100, 2'd0, 8'h07); popAndCheck();
    clr = 3'b100;
    tick(1);
    clr = 3'b000;
    tick(1);
    pushExpect("clr_strobe", 3'b000, 2'd1, 8'h00); popAndCheck();
    sig = 3'b000;
    tick(5);

    // hold suppresses edges; polarity writes never create spurious edges
    applyStimulus(3'b001, 1'b1, 1'b1, 3'b000);
    tick(5);
    hold = 1'b0;
    tick(2);
    pushExpect("hold", 3'b000, 2'd1, 8'h00); popAndCheck();
    regWrite(2'd3, 3'b110);
    tick(5);
    pushExpect("pol_flip", 3'b000, 2'd3, 8'h06); popAndCheck();
    regWrite(2'd3, 3'b111);
    tick(5);
    pushExpect("pol_back", 3'b000, 2'd1, 8'h00); popAndCheck();
    regWrite(2'd3, 3'b110);
    sig = 3'b000;
    tick(5);
    pushExpect("pol_fall", 3'b001, 2'd1, 8'h01); popAndCheck();
    regWrite(2'd1, 3'b001);
    regWrite(2'd3, 3'b111);
    tick(5);
    pushExpect("pol_restore", 3'b000, 2'd1, 8'h00); popAndCheck();

    // cen=0 freezes latching and ignores writes
    applyStimulus(3'b010, 1'b0, 1'b0, 3'b000);
    tick(8);
    pushExpect("cen_hold", 3'b000, 2'd1, 8'h00); popAndCheck();
    regWrite(2'd0, 3'b000);
    cen = 1'b1;
    tick(1);
    pushExpect("cen_lat", 3'b000, 2'd1, 8'h02); popAndCheck();
    tick(1);
    pushExpect("cen_pend", 3'b010, 2'd0, 8'h07); popAndCheck();
    sig = 3'b000;
    regWrite(2'd1, 3'b010);
    tick(5);

    // asynchronous reset with everything pending; no edge from lines high at release
    sig = 3'b111;
    tick(5);
    pushExpect("all_pend", 3'b111, 2'd1, 8'h07); popAndCheck();
    rst = 1'b1;
    pushExpect("rst_async", 3'b000, 2'd1, 8'h00); popAndCheck();
    pushExpect("rst_dout", 3'b000, 2'd0, 8'h00); popAndCheck();
    tick(2);
    rst = 1'b0;
    tick(8);
    pushExpect("rst_release", 3'b000, 2'd1, 8'h00); popAndCheck();
    sig = 3'b000;
    tick(5);
    sig = 3'b010;
    tick(1);
    sig = 3'b000;
    tick(4);
    pushExpect("post_rst", 3'b010, 2'd1, 8'h02); popAndCheck();

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
